// File: rtl/byte_pack_wr.sv
// rtl/byte_pack_wr.sv - byte stream to 32-bit RAM port-A word packer with auto-incrementing address
module byte_pack_wr #(
    parameter int WIDTH      = 32,
    parameter int WEA_WIDTH  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  ena,
    output logic [WEA_WIDTH-1:0]  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [WIDTH-1:0]      dina,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow
);

    localparam int LANE_W = (WEA_WIDTH > 1) ? $clog2(WEA_WIDTH) : 1;

    typedef enum logic {
        IDLE,
        PACK
    } state_t;

    state_t                  state;
    logic [LANE_W-1:0]       lane;
    logic [WEA_WIDTH-1:0]    mask;
    logic [WIDTH-1:0]        word;
    logic [ADDR_WIDTH-1:0]   addr_ptr;

    logic                    accept;
    logic                    complete;
    logic                    at_limit;
    logic [WEA_WIDTH-1:0]    mask_next;
    logic [WIDTH-1:0]        word_next;

    // Merge the incoming byte into the partial word; lane 0 is the most significant byte
    always_comb begin
        accept    = (state == PACK) && s_valid && s_ready;
        complete  = accept && ((lane == LANE_W'(WEA_WIDTH - 1)) || s_last);
        at_limit  = (wr_count == (ADDR_WIDTH + 1)'(DEPTH));
        mask_next = mask;
        word_next = word;
        mask_next[WEA_WIDTH - 1 - int'(lane)]       = 1'b1;
        word_next[WIDTH - 1 - 8 * int'(lane) -: 8] = s_data;
    end

    // Frame control, packing and registered RAM port-A outputs
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state    <= IDLE;
            lane     <= '0;
            mask     <= '0;
            word     <= '0;
            addr_ptr <= '0;
            s_ready  <= 1'b0;
            ena      <= 1'b0;
            wea      <= '0;
            addra    <= '0;
            dina     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
            overflow <= 1'b0;
        end else begin
            ena  <= 1'b0;
            wea  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_ptr <= base_addr;
                        lane     <= '0;
                        mask     <= '0;
                        word     <= '0;
                        wr_count <= '0;
                        overflow <= 1'b0;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= PACK;
                    end
                end
                PACK: begin
                    if (accept) begin
                        if (complete) begin
                            lane <= '0;
                            mask <= '0;
                            word <= '0;
                            // Past the frame limit the word is dropped but the stream keeps draining
                            if (at_limit) begin
                                overflow <= 1'b1;
                            end else begin
                                ena      <= 1'b1;
                                wea      <= mask_next;
                                dina     <= word_next;
                                addra    <= addr_ptr;
                                addr_ptr <= addr_ptr + 1'b1;
                                wr_count <= wr_count + 1'b1;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                            mask <= mask_next;
                            word <= word_next;
                        end
                        if (s_last) begin
                            done    <= 1'b1;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_pack_wr.sv
// tb/tb_byte_pack_wr.sv - scoreboard bench for byte_pack_wr
module tb_byte_pack_wr;

    localparam int DEPTH = 1024;

    logic        clka = 1'b0;
    logic        rsta_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        ena;
    logic [3:0]  wea;
    logic [9:0]  addra;
    logic [31:0] dina;
    logic        busy;
    logic        done;
    logic [10:0] wr_count;
    logic        overflow;

    byte_pack_wr dut (
        .clka(clka), .rsta_n(rsta_n), .start(start), .base_addr(base_addr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .busy(busy), .done(done), .wr_count(wr_count), .overflow(overflow)
    );

    always #5 clka = ~clka;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  w;
    } exp_wr_t;

    typedef struct {
        int cnt;
        bit ovf;
        int edg;
    } exp_done_t;

    exp_wr_t   wq[$];
    int        eq[$];
    exp_done_t dq[$];
    logic [7:0] frm[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit fin = 1'b0;

    always @(posedge clka) cyc <= cyc + 1;

    // Reference: chunk the frame into big-endian words of four bytes, writes beyond DEPTH are dropped
    task automatic model_frame(input logic [9:0] base);
        int n = frm.size();
        int nw = (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            exp_wr_t e;
            e.d = '0;
            e.w = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) begin
                    e.d = e.d | (32'(frm[4 * k + j]) << (24 - 8 * j));
                    e.w = e.w | (4'b1000 >> j);
                end
            end
            e.a = base + 10'(k);
            if (k < DEPTH) wq.push_back(e);
        end
    endtask

    task automatic run_frame(input logic [9:0] base, input int maxgap, input bit midstart);
        int n = frm.size();
        int nw = (n + 3) / 4;
        int to;
        model_frame(base);
        @(posedge clka); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clka); #1;
        start = 1'b0;
        base_addr = 10'($urandom);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            repeat ($urandom_range(maxgap, 0)) begin @(posedge clka); #1; end
            s_valid = 1'b1;
            s_data  = frm[i];
            s_last  = (i == n - 1);
            if (midstart && i < n - 1 && $urandom_range(3, 0) == 0) begin
                start = 1'b1;
                base_addr = 10'($urandom);
            end
            to = 0;
            while (!s_ready && to < 20) begin @(posedge clka); #1; to++; end
            if (!s_ready) begin
                $display("FAIL s_ready_timeout byte %0d got s_ready=0 want 1", i);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
                $fatal(1);
            end
            if ((i % 4 == 3 || i == n - 1) && (i / 4) < DEPTH) eq.push_back(cyc + 1);
            if (i == n - 1) begin
                exp_done_t d;
                d.cnt = (nw > DEPTH) ? DEPTH : nw;
                d.ovf = (nw > DEPTH);
                d.edg = cyc + 1;
                dq.push_back(d);
            end
            @(posedge clka); #1;
            start = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) begin @(posedge clka); #1; end
    endtask

    // Monitor: compares every DUT write and completion against the scoreboard queues
    always @(negedge clka) begin
        if (!rsta_n) begin
            vectors++;
            if ({s_ready, ena, wea, addra, dina, busy, done, wr_count, overflow} != '0) begin
                miscompares++;
                $display("FAIL reset_outputs got ena=%0b wea=%h addra=%h dina=%h rdy=%0b busy=%0b done=%0b cnt=%0d ovf=%0b want all 0",
                         ena, wea, addra, dina, s_ready, busy, done, wr_count, overflow);
            end
        end else begin
            vectors++;
            if (!ena && wea != 4'b0) begin
                miscompares++;
                $display("FAIL idle_wea got %b want 0000", wea);
            end
            if (ena) begin
                vectors++;
                if (wq.size() == 0 || eq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write got addra=%h dina=%h wea=%b want no write", addra, dina, wea);
                end else begin
                    exp_wr_t e;
                    int t;
                    e = wq.pop_front();
                    t = eq.pop_front();
                    if (addra != e.a || dina != e.d || wea != e.w || cyc != t) begin
                        miscompares++;
                        $display("FAIL write got addra=%h dina=%h wea=%b cyc=%0d want addra=%h dina=%h wea=%b cyc=%0d",
                                 addra, dina, wea, cyc, e.a, e.d, e.w, t);
                    end
                end
            end
            if (done) begin
                vectors++;
                if (dq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done got done=1 want 0");
                end else begin
                    exp_done_t d;
                    d = dq.pop_front();
                    if (int'(wr_count) != d.cnt || overflow != d.ovf || cyc != d.edg || s_ready || busy) begin
                        miscompares++;
                        $display("FAIL done got cnt=%0d ovf=%0b cyc=%0d rdy=%0b busy=%0b want cnt=%0d ovf=%0b cyc=%0d rdy=0 busy=0",
                                 wr_count, overflow, cyc, s_ready, busy, d.cnt, d.ovf, d.edg);
                    end
                end
            end
        end
        if (fin || cyc > 60000) begin
            vectors++;
            if (!fin || wq.size() != 0 || eq.size() != 0 || dq.size() != 0) begin
                miscompares++;
                $display("FAIL end_state got fin=%0b pending writes=%0d done=%0d want fin=1 and 0 pending",
                         fin, wq.size(), dq.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        repeat (3) @(posedge clka);
        #1 rsta_n = 1'b1;

        frm = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(10'h010, 0, 1'b0);

        frm = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        run_frame(10'h3FF, 0, 1'b0);

        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'($urandom));
        run_frame(10'($urandom), 3, 1'b0);

        frm.delete();
        for (int i = 0; i < 4 * DEPTH + 2; i++) frm.push_back(8'($urandom));
        run_frame(10'($urandom), 0, 1'b0);

        frm.delete();
        for (int i = 0; i < 5; i++) frm.push_back(8'($urandom));
        run_frame(10'($urandom), 1, 1'b0);

        // Abort a frame after two bytes of a word; the partial word must never reach the RAM
        @(posedge clka); #1;
        start = 1'b1;
        base_addr = 10'($urandom);
        @(posedge clka); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            @(posedge clka); #1;
        end
        s_valid = 1'b0;
        rsta_n  = 1'b0;
        repeat (3) @(posedge clka);
        #1 rsta_n = 1'b1;

        frm.delete();
        for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
        run_frame(10'($urandom), 0, 1'b0);

        frm.delete();
        for (int i = 0; i < 13; i++) frm.push_back(8'($urandom));
        run_frame(10'($urandom), 2, 1'b1);

        for (int f = 0; f < 6; f++) begin
            int n = $urandom_range(20, 1);
            frm.delete();
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
            run_frame(10'($urandom), $urandom_range(2, 0), 1'($urandom));
        end

        fin = 1'b1;
    end

endmodule
